// File: rtl/ballot_ctrl.sv
// ballot_ctrl: four-voter ballot sequencer for the majority rules
//   F = A.B.(C+D)   G = (A+B).C.D
// START opens a ballot, the first cast from each voter is latched, and once
// all four have voted the result is evaluated, registered and held until the
// next ballot.
// Optional feature: define BALLOT_TIMEOUT_EN to build a COLLECT-cycle counter
// that forces evaluation after TIMEOUT cycles and reports it on TMO.
module ballot_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       START,
    input  logic       ABORT,
    input  logic [3:0] CAST,
    input  logic [3:0] VOTE,
    output logic       F,
    output logic       G,
    output logic       DONE,
    output logic       BUSY,
    output logic [3:0] MASK,
    output logic       TMO
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_EVAL,
        S_RESULT
    } state_t;

    state_t     state;
    logic [3:0] v;
    logic [3:0] accept;
    logic       complete;

    // Only voters not yet in MASK may cast; a ballot is complete once the
    // accepted set including this cycle's new casts covers all four voters.
    assign accept   = CAST & ~MASK;
    assign complete = ((MASK | accept) == 4'hF);

`ifdef BALLOT_TIMEOUT_EN
    logic [7:0] cnt;
    logic       tmo_pend;
    logic       tmo_r;
    logic       timeout_hit;

    assign timeout_hit = (cnt == 8'(TIMEOUT - 1));
    assign TMO         = tmo_r;
`else
    localparam int unsigned unused_timeout = TIMEOUT;
    assign TMO = 1'b0;
`endif

    // Ballot FSM with all outputs registered; DONE defaults low so it can
    // only pulse on the EVAL->RESULT edge.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state    <= S_IDLE;
            v        <= 4'h0;
            MASK     <= 4'h0;
            F        <= 1'b0;
            G        <= 1'b0;
            DONE     <= 1'b0;
            BUSY     <= 1'b0;
`ifdef BALLOT_TIMEOUT_EN
            cnt      <= 8'h0;
            tmo_pend <= 1'b0;
            tmo_r    <= 1'b0;
`endif
        end else begin
            DONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    MASK <= 4'h0;
                    v    <= 4'h0;
`ifdef BALLOT_TIMEOUT_EN
                    cnt  <= 8'h0;
`endif
                    if (START) begin
                        state <= S_COLLECT;
                        BUSY  <= 1'b1;
                    end
                end
                S_COLLECT: begin
                    if (ABORT) begin
                        // Abort outranks completion and timeout; result regs untouched.
                        state <= S_IDLE;
                        BUSY  <= 1'b0;
                        MASK  <= 4'h0;
                        v     <= 4'h0;
                    end else begin
                        MASK <= MASK | accept;
                        v    <= (v & ~accept) | (VOTE & accept);
`ifdef BALLOT_TIMEOUT_EN
                        cnt  <= cnt + 8'd1;
`endif
                        if (complete) begin
                            state <= S_EVAL;
`ifdef BALLOT_TIMEOUT_EN
                            tmo_pend <= 1'b0;
`endif
                        end
`ifdef BALLOT_TIMEOUT_EN
                        else if (timeout_hit) begin
                            state    <= S_EVAL;
                            tmo_pend <= 1'b1;
                        end
`endif
                    end
                end
                S_EVAL: begin
                    // Unmasked voters hold 0 in v, so they count as a 0 vote.
                    F     <= v[0] & v[1] & (v[2] | v[3]);
                    G     <= (v[0] | v[1]) & v[2] & v[3];
                    DONE  <= 1'b1;
                    BUSY  <= 1'b0;
                    state <= S_RESULT;
`ifdef BALLOT_TIMEOUT_EN
                    tmo_r <= tmo_pend;
`endif
                end
                S_RESULT: begin
                    if (START) begin
                        state <= S_COLLECT;
                        BUSY  <= 1'b1;
                        MASK  <= 4'h0;
                        v     <= 4'h0;
`ifdef BALLOT_TIMEOUT_EN
                        cnt   <= 8'h0;
`endif
                    end
                end
                default: begin
                    state <= S_IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ballot_ctrl.sv
// Testbench for ballot_ctrl: table of full single-cycle ballots plus
// hand-written sequences for staggered casts, abort, timeout, reset and
// back-to-back ballots. Expected results are queued when the completing
// casts are driven and compared whenever DONE is seen.
module tb_ballot_ctrl;

    localparam int TO = 4;

    logic       CLK = 1'b0;
    logic       RSTN;
    logic       START;
    logic       ABORT;
    logic [3:0] CAST;
    logic [3:0] VOTE;
    logic       F;
    logic       G;
    logic       DONE;
    logic       BUSY;
    logic [3:0] MASK;
    logic       TMO;

    always #5 CLK = ~CLK;

    ballot_ctrl #(.TIMEOUT(TO)) dut (
        .CLK  (CLK),
        .RSTN (RSTN),
        .START(START),
        .ABORT(ABORT),
        .CAST (CAST),
        .VOTE (VOTE),
        .F    (F),
        .G    (G),
        .DONE (DONE),
        .BUSY (BUSY),
        .MASK (MASK),
        .TMO  (TMO)
    );

    typedef struct packed {
        logic       f;
        logic       g;
        logic       tmo;
        logic [3:0] mask;
    } exp_t;

    typedef struct {
        logic [3:0] vote;
        logic       f;
        logic       g;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[8];
    int   tests = 0;
    int   fails = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic push_exp(input logic f, input logic g, input logic tmo, input logic [3:0] mask);
        exp_t e;
        e.f    = f;
        e.g    = g;
        e.tmo  = tmo;
        e.mask = mask;
        sb.push_back(e);
    endtask

    // Scoreboard: every DONE pulse must match exactly one queued ballot.
    always @(negedge CLK) begin
        exp_t e;
        if (RSTN && DONE) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_done: got DONE=1, want 0 (t=%0t)", $time);
            end else begin
                e = sb.pop_front();
                chk1("res_f", F, e.f);
                chk1("res_g", G, e.g);
                chk1("res_tmo", TMO, e.tmo);
                chk4("res_mask", MASK, e.mask);
            end
        end
    end

    // All four voters cast at the first COLLECT edge; DONE lands 3 cycles after START.
    task automatic full_ballot(input logic [3:0] vote, input logic ef, input logic eg);
        START = 1'b1;
        tick;
        START = 1'b0;
        chk1("fb_busy_collect", BUSY, 1'b1);
        CAST = 4'hF;
        VOTE = vote;
        push_exp(ef, eg, 1'b0, 4'hF);
        tick;
        CAST = 4'h0;
        VOTE = 4'h0;
        chk4("fb_mask_eval", MASK, 4'hF);
        chk1("fb_done_eval", DONE, 1'b0);
        chk1("fb_busy_eval", BUSY, 1'b1);
        tick;
        chk1("fb_done", DONE, 1'b1);
        chk1("fb_busy_result", BUSY, 1'b0);
        tick;
        chk1("fb_done_once", DONE, 1'b0);
    endtask

    initial begin
        vecs[0] = '{4'b0111, 1'b1, 1'b0};
        vecs[1] = '{4'b1111, 1'b1, 1'b1};
        vecs[2] = '{4'b0000, 1'b0, 1'b0};
        vecs[3] = '{4'b1100, 1'b0, 1'b0};
        vecs[4] = '{4'b1101, 1'b0, 1'b1};
        vecs[5] = '{4'b1011, 1'b1, 1'b0};
        vecs[6] = '{4'b1110, 1'b0, 1'b1};
        vecs[7] = '{4'b0011, 1'b0, 1'b0};

        START = 1'b0;
        ABORT = 1'b0;
        CAST  = 4'h0;
        VOTE  = 4'h0;
        RSTN  = 1'b0;
        #12;
        chk1("rst_f", F, 1'b0);
        chk1("rst_g", G, 1'b0);
        chk1("rst_done", DONE, 1'b0);
        chk1("rst_busy", BUSY, 1'b0);
        chk4("rst_mask", MASK, 4'h0);
        chk1("rst_tmo", TMO, 1'b0);
        RSTN = 1'b1;
        tick;

        // Minimum ballot from IDLE
        full_ballot(vecs[0].vote, vecs[0].f, vecs[0].g);

        // Staggered casts with an ignored re-vote from A
        START = 1'b1;
        tick;
        START = 1'b0;
        CAST = 4'b0011;
        VOTE = 4'b0011;
        tick;
        chk4("stag_mask_ab", MASK, 4'b0011);
        CAST = 4'b0101;
        VOTE = 4'b0100;
        tick;
        chk4("stag_mask_abc", MASK, 4'b0111);
        CAST = 4'b1000;
        VOTE = 4'b1000;
        push_exp(1'b1, 1'b1, 1'b0, 4'hF);
        tick;
        CAST = 4'h0;
        VOTE = 4'h0;
        chk4("stag_mask_eval", MASK, 4'hF);
        chk1("stag_done_eval", DONE, 1'b0);
        tick;
        chk1("stag_done", DONE, 1'b1);
        tick;

        // Abort mid-ballot: back to IDLE, result held, no DONE
        START = 1'b1;
        tick;
        START = 1'b0;
        CAST = 4'b0011;
        VOTE = 4'b0011;
        tick;
        CAST = 4'h0;
        ABORT = 1'b1;
        tick;
        ABORT = 1'b0;
        chk4("abort_mask", MASK, 4'h0);
        chk1("abort_busy", BUSY, 1'b0);
        chk1("abort_f_hold", F, 1'b1);
        chk1("abort_g_hold", G, 1'b1);
        tick;
        tick;
        chk1("abort_no_done", DONE, 1'b0);

        // Abort together with completing casts: abort wins
        START = 1'b1;
        tick;
        START = 1'b0;
        CAST = 4'hF;
        VOTE = 4'hF;
        ABORT = 1'b1;
        tick;
        CAST = 4'h0;
        VOTE = 4'h0;
        ABORT = 1'b0;
        chk4("abortw_mask", MASK, 4'h0);
        chk1("abortw_busy", BUSY, 1'b0);
        tick;
        tick;
        chk1("abortw_no_done", DONE, 1'b0);

        // Table of full ballots
        for (int i = 1; i < 8; i++) begin
            full_ballot(vecs[i].vote, vecs[i].f, vecs[i].g);
        end

        // Back-to-back: START in the DONE cycle
        START = 1'b1;
        tick;
        START = 1'b0;
        CAST = 4'hF;
        VOTE = 4'hF;
        push_exp(1'b1, 1'b1, 1'b0, 4'hF);
        tick;
        CAST = 4'h0;
        VOTE = 4'h0;
        tick;
        chk1("b2b_done1", DONE, 1'b1);
        START = 1'b1;
        tick;
        START = 1'b0;
        chk1("b2b_busy2", BUSY, 1'b1);
        chk1("b2b_done_low", DONE, 1'b0);
        chk1("b2b_f_hold", F, 1'b1);
        chk1("b2b_g_hold", G, 1'b1);
        CAST = 4'hF;
        VOTE = 4'h0;
        push_exp(1'b0, 1'b0, 1'b0, 4'hF);
        tick;
        CAST = 4'h0;
        chk1("b2b_f_hold_eval", F, 1'b1);
        chk1("b2b_done_eval", DONE, 1'b0);
        tick;
        chk1("b2b_done2", DONE, 1'b1);
        tick;
        chk1("b2b_done2_once", DONE, 1'b0);

`ifdef BALLOT_TIMEOUT_EN
        // Timeout with only C and D cast: forced close after TO COLLECT cycles
        START = 1'b1;
        tick;
        START = 1'b0;
        CAST = 4'b1100;
        VOTE = 4'b1100;
        push_exp(1'b0, 1'b0, 1'b1, 4'b1100);
        tick;
        CAST = 4'h0;
        VOTE = 4'h0;
        tick;
        tick;
        chk1("tmo_busy_c4", BUSY, 1'b1);
        chk1("tmo_done_c4", DONE, 1'b0);
        tick;
        chk4("tmo_mask_eval", MASK, 4'b1100);
        chk1("tmo_done_eval", DONE, 1'b0);
        chk1("tmo_busy_eval", BUSY, 1'b1);
        tick;
        chk1("tmo_done", DONE, 1'b1);
        chk1("tmo_busy_result", BUSY, 1'b0);
        tick;
        chk1("tmo_done_once", DONE, 1'b0);

        // Completing cast in the timeout cycle wins
        START = 1'b1;
        tick;
        START = 1'b0;
        CAST = 4'b0111;
        VOTE = 4'b0111;
        tick;
        CAST = 4'h0;
        VOTE = 4'h0;
        tick;
        chk1("tmo2_tmo_hold", TMO, 1'b1);
        tick;
        CAST = 4'b1000;
        VOTE = 4'b1000;
        push_exp(1'b1, 1'b1, 1'b0, 4'hF);
        tick;
        CAST = 4'h0;
        VOTE = 4'h0;
        chk4("tmo2_mask_eval", MASK, 4'hF);
        tick;
        chk1("tmo2_done", DONE, 1'b1);
        tick;
`endif

        // Reset in the middle of COLLECT
        START = 1'b1;
        tick;
        START = 1'b0;
        CAST = 4'b0101;
        VOTE = 4'b0101;
        tick;
        CAST = 4'h0;
        VOTE = 4'h0;
        chk4("mid_mask", MASK, 4'b0101);
        chk1("mid_busy", BUSY, 1'b1);
        #2;
        RSTN = 1'b0;
        #1;
        chk1("mrst_f", F, 1'b0);
        chk1("mrst_g", G, 1'b0);
        chk1("mrst_done", DONE, 1'b0);
        chk1("mrst_busy", BUSY, 1'b0);
        chk4("mrst_mask", MASK, 4'h0);
        chk1("mrst_tmo", TMO, 1'b0);
        #4;
        RSTN = 1'b1;
        tick;
        CAST = 4'hF;
        VOTE = 4'hF;
        tick;
        tick;
        chk4("post_rst_mask", MASK, 4'h0);
        chk1("post_rst_busy", BUSY, 1'b0);
        chk1("post_rst_done", DONE, 1'b0);
        CAST = 4'h0;
        VOTE = 4'h0;

        tick;
        tick;
        chk1("sb_empty", sb.size() == 0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
